// File: rtl/noc_input_vc_buffer.sv
// Per-port input stage: per-VC FIFOs, round-robin VC selection with packet lock, one flit out per cycle.
// Write-to-read latency 1 cycle; ready_o[v] is full-ness only, and a stalled output is held stable until accepted.

module noc_vc_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (!push && pop) occ <= occ - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module noc_input_vc_buffer #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3,
  parameter int VC_W       = 2,
  parameter int BUFF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic [VC_W-1:0]       vc_id_i,
  input  logic                  valid_i,
  output logic [N_VIRT_CHN-1:0] ready_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic [VC_W-1:0]       vc_id_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o
);
  localparam int CW = $clog2(BUFF_DEPTH) + 1;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [VC_W-1:0] lock_vc;
  logic [VC_W-1:0] rr_ptr;
  logic            hold_vld;
  logic [VC_W-1:0] hold_vc;

  logic [N_VIRT_CHN-1:0] push;
  logic [N_VIRT_CHN-1:0] pop;
  logic [N_VIRT_CHN-1:0] nonempty;
  logic [FLIT_WIDTH-1:0] head [N_VIRT_CHN];
  logic [CW-1:0]         occ  [N_VIRT_CHN];

  logic                  cand_found;
  logic [VC_W-1:0]       cand;
  logic [VC_W-1:0]       sel_vc;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  sel_ne;
  logic [1:0]            sel_type;
  logic                  is_head;
  logic                  out_vld;
  logic                  discard;
  logic                  fire;

  for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
    assign ready_o[v]  = (occ[v] != CW'(BUFF_DEPTH));
    assign nonempty[v] = (occ[v] != '0);
    assign push[v]     = valid_i && (vc_id_i == VC_W'(v)) && ready_o[v];
    assign pop[v]      = (sel_vc == VC_W'(v)) && (fire || discard);

    noc_vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (BUFF_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .arst   (arst),
      .push   (push[v]),
      .pop    (pop[v]),
      .wr_dat (flit_i),
      .rd_dat (head[v]),
      .occ    (occ[v])
    );
  end

  // A stalled IDLE grant is pinned so a later write to a higher-priority VC cannot swap the presented flit.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    if (hold_vld) begin
      cand_found = 1'b1;
      cand       = hold_vc;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        if (!cand_found && nonempty[v] && (VC_W'(v) >= rr_ptr)) begin
          cand_found = 1'b1;
          cand       = VC_W'(v);
        end
      end
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        if (!cand_found && nonempty[v] && (VC_W'(v) < rr_ptr)) begin
          cand_found = 1'b1;
          cand       = VC_W'(v);
        end
      end
    end
  end

  assign sel_vc = (state == LOCKED) ? lock_vc : cand;

  always_comb begin
    sel_flit = '0;
    sel_ne   = 1'b0;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (sel_vc == VC_W'(v)) begin
        sel_flit = head[v];
        sel_ne   = nonempty[v];
      end
    end
  end

  assign sel_type = sel_flit[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign is_head  = (sel_type == T_HEAD) || (sel_type == T_HT);
  assign out_vld  = (state == LOCKED) ? sel_ne : (cand_found && is_head);
  assign discard  = (state == IDLE) && cand_found && !is_head;
  assign fire     = out_vld && ready_i;

  assign valid_o = out_vld;
  assign err_o   = discard;
  assign flit_o  = out_vld ? sel_flit : '0;
  assign vc_id_o = out_vld ? sel_vc : '0;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state    <= IDLE;
      lock_vc  <= '0;
      rr_ptr   <= '0;
      hold_vld <= 1'b0;
      hold_vc  <= '0;
    end else begin
      hold_vld <= (state == IDLE) && out_vld && !ready_i;
      hold_vc  <= sel_vc;
      case (state)
        IDLE: begin
          if (fire) begin
            rr_ptr <= (sel_vc == VC_W'(N_VIRT_CHN - 1)) ? '0 : sel_vc + VC_W'(1);
            if (sel_type == T_HEAD) begin
              state   <= LOCKED;
              lock_vc <= sel_vc;
            end
          end
        end
        LOCKED: begin
          if (fire && (sel_type == T_TAIL)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
